// File: rtl/bus_fabric_pkg.sv
// Shared types and helpers for the single-master local-bus fabric.
package bus_fabric_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        RESP
    } state_t;

    localparam logic [31:0]  DEFAULT_ERR_DATA = 32'hDEAD_BEEF;
    localparam logic [3:0]   LBUS_ADDR_PAD    = 4'h0;
    localparam int unsigned  MAX_SLAVES       = 16;
    localparam int unsigned  SLAVE_IDX_W      = 4;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [SLAVE_IDX_W-1:0] lowest_set(input logic [MAX_SLAVES-1:0] vec);
        logic [SLAVE_IDX_W-1:0] idx;
        idx = '0;
        for (int i = int'(MAX_SLAVES) - 1; i >= 0; i--) begin
            if (vec[i]) idx = SLAVE_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_addr_decode.sv
// Base/mask address decode producing a priority-resolved one-hot slave select.
module bus_addr_decode
    import bus_fabric_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = '0
) (
    input  logic [31:0]           addr,
    output logic [NUM_SLAVES-1:0] hit,
    output logic                  any_hit
);

    logic [NUM_SLAVES-1:0] raw_hit;

    always_comb begin
        raw_hit = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            raw_hit[k] = (addr & SLAVE_MASK[k*32 +: 32]) == SLAVE_BASE[k*32 +: 32];
        end
    end

    assign any_hit = |raw_hit;

    // Overlapping windows resolve to the lowest slave index.
    assign hit = any_hit ? (NUM_SLAVES'(1) << lowest_set(MAX_SLAVES'(raw_hit))) : '0;

endmodule

// File: rtl/bus_fabric.sv
// Single-master interconnect: address map, busy handshake, response tracking,
// timeout and sticky error reporting.
module bus_fabric
    import bus_fabric_pkg::*;
#(
    parameter int unsigned              NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE = {32'h3000_0000, 32'h2000_0000,
                                                      32'h1000_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK = {4{32'hF000_0000}},
    parameter int unsigned              TIMEOUT    = 255,
    parameter logic [31:0]              ERR_DATA   = DEFAULT_ERR_DATA
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              m_addr,
    input  logic [31:0]              m_wdata,
    input  logic [3:0]               m_wmask,
    input  logic                     m_rstrb,
    output logic [31:0]              m_rdata,
    output logic                     m_rbusy,
    output logic                     m_wbusy,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    output logic [3:0]               s_wstrb,
    output logic [NUM_SLAVES-1:0]    s_wen,
    output logic [NUM_SLAVES-1:0]    s_ren,
    input  logic [NUM_SLAVES-1:0]    s_wready,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_rvalid,
    output logic                     err_irq,
    output logic [31:0]              err_addr,
    input  logic                     err_clr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t                state_q, state_d;
    logic [31:0]           addr_q, wdata_q, rdata_q, err_addr_q;
    logic [3:0]            wstrb_q;
    logic [NUM_SLAVES-1:0] sel_q, hit;
    logic                  any_hit;
    logic [CNT_W-1:0]      cnt_q;
    logic                  err_irq_q;

    logic                  wr_req, timed_out;
    logic                  accept, rd_done, rd_err, err_evt;
    logic                  sel_rvalid, sel_wready;
    logic [31:0]           sel_rdata, err_src;

    bus_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_BASE (SLAVE_BASE),
        .SLAVE_MASK (SLAVE_MASK)
    ) u_decode (
        .addr    (m_addr),
        .hit     (hit),
        .any_hit (any_hit)
    );

    assign wr_req     = |m_wmask;
    assign timed_out  = cnt_q == CNT_W'(TIMEOUT);
    assign sel_rvalid = |(s_rvalid & sel_q);
    assign sel_wready = |(s_wready & sel_q);

    // Read data from the latched slave only.
    always_comb begin
        sel_rdata = '0;
        for (int k = 0; k < int'(NUM_SLAVES); k++) begin
            sel_rdata = sel_rdata | (s_rdata[k*32 +: 32] & {32{sel_q[k]}});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state, slave pulses and busy toward the core.
    always_comb begin
        state_d = state_q;
        s_ren   = '0;
        s_wen   = '0;
        m_rbusy = 1'b0;
        m_wbusy = 1'b0;
        accept  = 1'b0;
        rd_done = 1'b0;
        rd_err  = 1'b0;
        err_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (wr_req) begin
                    accept  = 1'b1;
                    m_wbusy = 1'b1;
                    s_wen   = hit;
                    if (!any_hit) begin
                        err_evt = 1'b1;
                        state_d = RESP;
                    end else if (|(s_wready & hit)) begin
                        state_d = RESP;
                    end else begin
                        state_d = WR_WAIT;
                    end
                end else if (m_rstrb) begin
                    accept  = 1'b1;
                    m_rbusy = 1'b1;
                    s_ren   = hit;
                    if (!any_hit) begin
                        err_evt = 1'b1;
                        rd_err  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                m_rbusy = 1'b1;
                if (sel_rvalid) begin
                    rd_done = 1'b1;
                    state_d = RESP;
                end else if (timed_out) begin
                    err_evt = 1'b1;
                    rd_err  = 1'b1;
                    state_d = RESP;
                end
            end
            WR_WAIT: begin
                m_wbusy = 1'b1;
                if (sel_wready) begin
                    state_d = RESP;
                end else if (timed_out) begin
                    err_evt = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // In the strobe cycle the slave bus mirrors the core; afterwards it holds the latch.
    assign s_addr  = accept ? {LBUS_ADDR_PAD, m_addr[27:0]} : {LBUS_ADDR_PAD, addr_q[27:0]};
    assign s_wdata = accept ? m_wdata : wdata_q;
    assign s_wstrb = accept ? m_wmask : wstrb_q;
    assign err_src = (state_q == IDLE) ? m_addr : addr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= m_addr;
                wdata_q <= m_wdata;
                wstrb_q <= m_wmask;
                sel_q   <= hit;
                cnt_q   <= CNT_W'(1);
            end else if (state_q == RD_WAIT || state_q == WR_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (rd_done)     rdata_q <= sel_rdata;
            else if (rd_err) rdata_q <= ERR_DATA;
        end
    end

    // Sticky error: first address is kept until software clears; a new error beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_irq_q  <= 1'b0;
            err_addr_q <= '0;
        end else if (err_evt) begin
            if (!err_irq_q) err_addr_q <= err_src;
            err_irq_q <= 1'b1;
        end else if (err_clr) begin
            err_irq_q <= 1'b0;
        end
    end

    assign m_rdata  = rdata_q;
    assign err_irq  = err_irq_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_bus_fabric.sv
// Directed bench for bus_fabric with a response scoreboard.
module tb_bus_fabric;

    localparam int unsigned NS = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [31:0]    m_addr, m_wdata, m_rdata;
    logic [3:0]     m_wmask;
    logic           m_rstrb, m_rbusy, m_wbusy;
    logic [31:0]    s_addr, s_wdata;
    logic [3:0]     s_wstrb;
    logic [NS-1:0]  s_wen, s_ren, s_wready, s_rvalid;
    logic [NS*32-1:0] s_rdata;
    logic           err_irq, err_clr;
    logic [31:0]    err_addr;

    bus_fabric #(
        .NUM_SLAVES (NS),
        .SLAVE_BASE ({32'h1000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
        .SLAVE_MASK ({4{32'hF000_0000}}),
        .TIMEOUT    (8),
        .ERR_DATA   (32'hDEAD_BEEF)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wmask  (m_wmask),
        .m_rstrb  (m_rstrb),
        .m_rdata  (m_rdata),
        .m_rbusy  (m_rbusy),
        .m_wbusy  (m_wbusy),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_wstrb  (s_wstrb),
        .s_wen    (s_wen),
        .s_ren    (s_ren),
        .s_wready (s_wready),
        .s_rdata  (s_rdata),
        .s_rvalid (s_rvalid),
        .err_irq  (err_irq),
        .err_addr (err_addr),
        .err_clr  (err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        is_rd;
        logic [31:0] rdata;
        int          resp_cyc;
        logic        err;
        logic [31:0] eaddr;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic busy_prev = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void expect_resp(input logic is_rd, input logic [31:0] rdata, input int lat,
                                        input logic err, input logic [31:0] eaddr);
        exp_t e;
        e.is_rd    = is_rd;
        e.rdata    = rdata;
        e.resp_cyc = cyc + lat;
        e.err      = err;
        e.eaddr    = eaddr;
        exp_q.push_back(e);
    endfunction

    // Monitor: a response is the first non-busy cycle after a busy one.
    always @(negedge clk) begin
        exp_t e;
        logic busy_now;
        if (!reset_n) begin
            busy_prev = 1'b0;
        end else begin
            busy_now = m_rbusy | m_wbusy;
            if (busy_prev && !busy_now) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_resp: response at cycle %0d with nothing expected", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_cycle", 32'(cyc), 32'(e.resp_cyc));
                    if (e.is_rd) check("resp_rdata", m_rdata, e.rdata);
                    check("resp_err_irq", 32'(err_irq), 32'(e.err));
                    check("resp_err_addr", err_addr, e.eaddr);
                end
            end
            busy_prev = busy_now;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_addr   = '0;
        m_wdata  = '0;
        m_wmask  = '0;
        m_rstrb  = 1'b0;
        s_wready = '0;
        s_rvalid = '0;
        s_rdata  = '0;
        err_clr  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            step();
            n++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_busy", 32'({m_rbusy, m_wbusy}), 32'h0);
        check("rst_s_en", 32'({s_ren, s_wen}), 32'h0);
        check("rst_s_addr", s_addr, 32'h0);
        check("rst_err", 32'(err_irq), 32'h0);
        check("rst_err_addr", err_addr, 32'h0);

        // Minimum-latency read of slave 0
        step();
        m_addr = 32'h0000_0010; m_rstrb = 1'b1;
        expect_resp(1'b1, 32'h1234_5678, 2, 1'b0, 32'h0);
        #1;
        check("rd0_s_ren", 32'(s_ren), 32'b0001);
        check("rd0_rbusy", 32'(m_rbusy), 32'd1);
        check("rd0_s_addr", s_addr, 32'h0000_0010);
        step();
        m_rstrb = 1'b0; s_rvalid = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
        #1;
        check("rd1_s_ren", 32'(s_ren), 32'd0);
        check("rd1_rbusy", 32'(m_rbusy), 32'd1);
        step();
        s_rvalid = '0;
        #1 check("rd2_rbusy", 32'(m_rbusy), 32'd0);
        drain();

        // Write to slave 1, ready three cycles later
        step();
        m_addr = 32'h1000_0004; m_wdata = 32'hAABB_CCDD; m_wmask = 4'b0011;
        expect_resp(1'b0, 32'h0, 4, 1'b0, 32'h0);
        #1;
        check("wr0_s_wen", 32'(s_wen), 32'b0010);
        check("wr0_wbusy", 32'(m_wbusy), 32'd1);
        check("wr0_s_wstrb", 32'(s_wstrb), 32'b0011);
        check("wr0_s_addr", s_addr, 32'h0000_0004);
        check("wr0_s_wdata", s_wdata, 32'hAABB_CCDD);
        step();
        m_wmask = '0; m_addr = '0; m_wdata = '0;
        #1;
        check("wr1_s_wen", 32'(s_wen), 32'd0);
        check("wr1_s_addr", s_addr, 32'h0000_0004);
        check("wr1_s_wstrb", 32'(s_wstrb), 32'b0011);
        check("wr1_wbusy", 32'(m_wbusy), 32'd1);
        step();
        step();
        s_wready = 4'b0010;
        step();
        s_wready = '0;
        #1 check("wr4_wbusy", 32'(m_wbusy), 32'd0);
        drain();

        // Unmapped read
        step();
        m_addr = 32'h5000_0000; m_rstrb = 1'b1;
        expect_resp(1'b1, 32'hDEAD_BEEF, 1, 1'b1, 32'h5000_0000);
        #1;
        check("um_s_ren", 32'(s_ren), 32'd0);
        check("um_rbusy", 32'(m_rbusy), 32'd1);
        step();
        m_rstrb = 1'b0; m_addr = '0;
        drain();
        step();
        err_clr = 1'b1;
        #1 check("clr_same_cycle", 32'(err_irq), 32'd1);
        step();
        err_clr = 1'b0;
        #1;
        check("clr_err_irq", 32'(err_irq), 32'd0);
        check("clr_err_addr", err_addr, 32'h5000_0000);

        // Read timeout on slave 2
        step();
        m_addr = 32'h2000_0040; m_rstrb = 1'b1;
        expect_resp(1'b1, 32'hDEAD_BEEF, 9, 1'b1, 32'h2000_0040);
        #1 check("to_s_ren", 32'(s_ren), 32'b0100);
        step();
        m_rstrb = 1'b0; m_addr = '0;
        drain();

        // Write timeout with err_clr in the error cycle: address kept, set wins
        step();
        m_addr = 32'h2000_0080; m_wmask = 4'b1111; m_wdata = 32'h5555_AAAA;
        expect_resp(1'b0, 32'h0, 9, 1'b1, 32'h2000_0040);
        #1 check("to2_s_wen", 32'(s_wen), 32'b0100);
        step();
        m_wmask = '0; m_addr = '0;
        repeat (7) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        drain();
        step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        #1;
        check("clr2_err_irq", 32'(err_irq), 32'd0);
        check("clr2_err_addr", err_addr, 32'h2000_0040);

        // Overlapping map: slave 1 beats slave 3; stray strobe and rvalid ignored
        step();
        m_addr = 32'h1000_0100; m_rstrb = 1'b1;
        expect_resp(1'b1, 32'hCAFE_F00D, 3, 1'b0, 32'h2000_0040);
        #1 check("ov_s_ren", 32'(s_ren), 32'b0010);
        step();
        m_addr = 32'h0000_0000;
        s_rvalid = 4'b1000; s_rdata[127:96] = 32'hFFFF_FFFF;
        #1;
        check("ov_stray_s_ren", 32'(s_ren), 32'd0);
        check("ov_stray_s_addr", s_addr, 32'h0000_0100);
        step();
        m_rstrb = 1'b0;
        s_rvalid = 4'b0010; s_rdata[63:32] = 32'hCAFE_F00D;
        #1 check("ov_rbusy", 32'(m_rbusy), 32'd1);
        step();
        s_rvalid = '0;
        drain();

        // Read and write strobes together: write only, minimum write latency
        step();
        m_addr = 32'h0000_0020; m_wdata = 32'h1122_3344; m_wmask = 4'b1111; m_rstrb = 1'b1;
        s_wready = 4'b0001;
        expect_resp(1'b0, 32'h0, 1, 1'b0, 32'h2000_0040);
        #1;
        check("rw_s_wen", 32'(s_wen), 32'b0001);
        check("rw_s_ren", 32'(s_ren), 32'd0);
        check("rw_busy", 32'({m_rbusy, m_wbusy}), 32'b01);
        step();
        idle_inputs();
        #1 check("rw_wbusy_low", 32'(m_wbusy), 32'd0);
        drain();

        // Reset during RD_WAIT aborts the access
        step();
        m_addr = 32'h0000_0030; m_rstrb = 1'b1;
        #1 check("ra_rbusy", 32'(m_rbusy), 32'd1);
        step();
        m_rstrb = 1'b0;
        reset_n = 1'b0;
        #1;
        check("ra_busy", 32'({m_rbusy, m_wbusy}), 32'd0);
        check("ra_s_addr", s_addr, 32'h0);
        check("ra_s_wdata", s_wdata, 32'h0);
        check("ra_m_rdata", m_rdata, 32'h0);
        check("ra_err", 32'(err_irq), 32'd0);
        check("ra_err_addr", err_addr, 32'h0);
        step();
        step();
        reset_n = 1'b1;
        step();
        s_rvalid = 4'b0001; s_rdata[31:0] = 32'h9999_9999;
        #1 check("late_rbusy", 32'(m_rbusy), 32'd0);
        step();
        s_rvalid = '0;
        #1 check("late_m_rdata", m_rdata, 32'h0);

        // Normal read after reset
        step();
        m_addr = 32'h0000_0040; m_rstrb = 1'b1;
        expect_resp(1'b1, 32'h0BAD_CAFE, 2, 1'b0, 32'h0);
        step();
        m_rstrb = 1'b0; s_rvalid = 4'b0001; s_rdata[31:0] = 32'h0BAD_CAFE;
        step();
        s_rvalid = '0;
        drain();

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bus_fabric.md
# bus_fabric

Parametrised single-master interconnect between the FemtoRV32 memory port and up to NUM_SLAVES local-bus peripherals (memory, GPIO, UART, I2C, …). It replaces the fixed three-way select and combinational read mux with three things: a configurable base/mask address map, real busy handshaking toward the core, and per-access response tracking. A timeout and error reporting cover unmapped or unresponsive slaves.

## Interface
- NUM_SLAVES, 4, number of slave ports (1..16)
- SLAVE_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}, flattened NUM_SLAVES×32 base addresses, slave k at bits [32k+31:32k]
- SLAVE_MASK, {4{32'hF000_0000}}, flattened NUM_SLAVES×32 compare masks; hit_k = ((m_addr & MASK_k) == BASE_k)
- TIMEOUT, 255, response cycles allowed before error (≥1, counter width $clog2(TIMEOUT+1))
- ERR_DATA, 32'hDEAD_BEEF, read data returned on error

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- m_addr  in  32  core byte address
- m_wdata  in  32  core write data
- m_wmask  in  4  core write byte mask; nonzero for one cycle = write strobe
- m_rstrb  in  1  core read strobe, one cycle
- m_rdata  out  32  read data, valid in first cycle m_rbusy is low after a read
- m_rbusy  out  1  read in progress
- m_wbusy  out  1  write in progress
- s_addr  out  32  latched access address, {4'h0, addr[27:0]}
- s_wdata  out  32  latched write data
- s_wstrb  out  4  latched write mask
- s_wen  out  NUM_SLAVES  one-hot write pulse
- s_ren  out  NUM_SLAVES  one-hot read pulse
- s_wready  in  NUM_SLAVES  slave write accepted
- s_rdata  in  NUM_SLAVES×32  slave read data
- s_rvalid  in  NUM_SLAVES  slave read data valid
- err_irq  out  1  sticky error flag
- err_addr  out  32  address of the first unacknowledged error
- err_clr  in  1  clears err_irq (err_addr stays until next error)

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT, RESP.
- IDLE, strobe seen: latch addr/wdata/wmask, decode, select = lowest-index hit.
  - Write (|m_wmask): pulse s_wen[sel] for one cycle, go to WR_WAIT.
  - Read (m_rstrb): pulse s_ren[sel] for one cycle, go to RD_WAIT.
  - m_rstrb and m_wmask together: write wins, read dropped.
- Unmapped address (no hit): no s_ren/s_wen; go straight to RESP with an error.
- RD_WAIT: sample s_rvalid[sel] from the cycle after the s_ren pulse. On valid, capture s_rdata[sel] into rdata_q and go to RESP.
- WR_WAIT: sample s_wready[sel] from the s_wen cycle onward. On ready, go to RESP.
- Either wait state: timeout counter reaches TIMEOUT → error; go to RESP.
  - A read returns ERR_DATA; a write is dropped.
- Error event: if err_irq = 0, capture the latched address into err_addr; set err_irq. Later errors do not overwrite err_addr while err_irq = 1.
- err_clr and a new error in the same cycle: set wins.
- RESP: one cycle, busy low, m_rdata = rdata_q; go to IDLE.
- Strobes arriving outside IDLE are ignored.
- s_rvalid/s_wready from non-selected slaves are ignored.

## Timing
- Reset: state IDLE, all outputs 0, counter 0, rdata_q 0.
- Reset mid-access aborts the access without a response.
- m_rbusy / m_wbusy:
  - Combinationally high in the strobe cycle when the address is mapped.
  - Registered high through all wait cycles.
  - Low in RESP.
  - An unmapped strobe also holds busy high in the strobe cycle.
- Minimum read: strobe at cycle 0, s_ren at 0, s_rvalid at 1, RESP at 2 (m_rdata valid, rbusy low).
- Minimum write: strobe at 0, s_wready at 0, RESP at 1.
- Unmapped access: RESP at 1.
- Timeout: strobe at 0 with no response → error and RESP at cycle TIMEOUT+1.
- Decode is combinational on m_addr. s_addr/s_wdata/s_wstrb are registered and stable from cycle 1 to RESP; in cycle 0 they are driven combinationally from m_* inputs.

## Structure
- Package bus_fabric_pkg holds:
  - the state enum
  - the localparams DEFAULT_ERR_DATA and LBUS_ADDR_PAD (4'h0)
  - a function returning the lowest set bit index of a hit vector
- Sub-module bus_addr_decode, the generalised device select: m_addr, SLAVE_BASE/MASK → one-hot hit[NUM_SLAVES] (priority-resolved) and any_hit.

## Test plan
- Read slave 0 at 0x0000_0010; slave responds rvalid next cycle with 0x1234_5678 → m_rbusy high for cycles 0–1, m_rdata = 0x1234_5678 at cycle 2, s_ren = 4'b0001 only at cycle 0.
- Write 0xAABB_CCDD, mask 4'b0011, to 0x1000_0004; slave 1 wready 3 cycles later → s_wen[1] one pulse, s_wstrb = 4'b0011, s_addr = 0x0000_0004, m_wbusy low at cycle 4.
- Read 0x5000_0000 (unmapped) → no s_ren, m_rdata = 0xDEAD_BEEF at cycle 1, err_irq = 1, err_addr = 0x5000_0000.
- TIMEOUT = 8, slave 2 never responds → ERR_DATA at cycle 9. A second timeout leaves err_addr unchanged. err_clr drops err_irq the next cycle.
- Overlapping map (slaves 1 and 3 both hit) → only slave 1 selected. Simultaneous m_rstrb + m_wmask → write only.
- reset_n low during RD_WAIT → all outputs 0 immediately. A late s_rvalid after reset release is ignored, and the next read completes normally.
